comp_checker: RTL

COMP_CHECKER -- requirements
Module: comp_checker

---
 rtl/comp_pkg.sv | 19 +
 rtl/comp_expect.sv | 19 +
 rtl/comp_checker.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared definitions for the comparator sweep checker: FSM state encoding,
// default operand width and the legal range of the settle delay.
package comp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int WIDTH_DEFAULT  = 2;
   localparam int SETTLE_DEFAULT = 1;
   localparam int SETTLE_MIN     = 1;
   localparam int SETTLE_MAX     = 15;
   // Counter width able to hold SETTLE_MAX-1
   localparam int SETTLE_W       = 4;

endpackage : comp_pkg

// File: rtl/comp_expect.sv
// Combinational reference: the flags an ideal unsigned comparator produces.
module comp_expect #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   // Unsigned reference comparison of the driven operand pair
   always_comb begin
      eq = (a == b);
      lt = (a <  b);
      gt = (a >  b);
   end

endmodule : comp_expect

// File: rtl/comp_checker.sv
// Exhaustive comparator sweep checker. Drives every {a,b} pair, waits SETTLE
// cycles, compares the returned flags with comp_expect and counts mismatches.
// Optional feature macro: COMP_CHK_FIRST_FAIL_EN adds first-failure capture.
module comp_checker
   import comp_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEFAULT,
   parameter int SETTLE = SETTLE_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   input  logic               Eq,
   input  logic               Less,
   input  logic               Greater,
   output logic               busy,
   output logic               done,
   output logic               pass,
`ifdef COMP_CHK_FIRST_FAIL_EN
   output logic               first_fail_vld,
   output logic [WIDTH-1:0]   first_fail_a,
   output logic [WIDTH-1:0]   first_fail_b,
`endif
   output logic [2*WIDTH:0]   err_cnt
);

   localparam int IW = 2 * WIDTH;
   localparam int CW = 2 * WIDTH + 1;
   localparam logic [IW-1:0]       IDX_LAST  = {IW{1'b1}};
   localparam logic [CW-1:0]       ERR_MAX   = {CW{1'b1}};
   localparam logic [SETTLE_W-1:0] WAIT_LAST = SETTLE_W'(SETTLE - 1);

   state_t              state;
   logic [IW-1:0]       idx;
   logic [IW-1:0]       idx_inc;
   logic [SETTLE_W-1:0] wait_cnt;
   logic [CW-1:0]       err_next;
   logic                exp_eq;
   logic                exp_lt;
   logic                exp_gt;
   logic                mismatch;

   comp_expect #(.WIDTH(WIDTH)) u_expect (
      .a  (a),
      .b  (b),
      .eq (exp_eq),
      .lt (exp_lt),
      .gt (exp_gt)
   );

   // Flag comparison and next error count; any deviation, including
   // non-one-hot flags, is a single mismatch. The count saturates.
   always_comb begin
      idx_inc  = idx + IW'(1);
      mismatch = ({Eq, Less, Greater} != {exp_eq, exp_lt, exp_gt});
      if (mismatch && (err_cnt != ERR_MAX)) begin
         err_next = err_cnt + CW'(1);
      end else begin
         err_next = err_cnt;
      end
   end

   // Sweep FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         a        <= '0;
         b        <= '0;
         wait_cnt <= '0;
         err_cnt  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
`ifdef COMP_CHK_FIRST_FAIL_EN
         first_fail_vld <= 1'b0;
         first_fail_a   <= '0;
         first_fail_b   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  idx      <= '0;
                  a        <= '0;
                  b        <= '0;
                  wait_cnt <= '0;
                  err_cnt  <= '0;
                  pass     <= 1'b0;
                  busy     <= 1'b1;
                  state    <= WAIT;
`ifdef COMP_CHK_FIRST_FAIL_EN
                  first_fail_vld <= 1'b0;
                  first_fail_a   <= '0;
                  first_fail_b   <= '0;
`endif
               end
            end
            WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state <= CHECK;
               end else begin
                  wait_cnt <= wait_cnt + SETTLE_W'(1);
               end
            end
            CHECK: begin
               err_cnt <= err_next;
`ifdef COMP_CHK_FIRST_FAIL_EN
               if (mismatch && !first_fail_vld) begin
                  first_fail_vld <= 1'b1;
                  first_fail_a   <= a;
                  first_fail_b   <= b;
               end
`endif
               if (idx == IDX_LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
                  state <= DONE;
               end else begin
                  idx      <= idx_inc;
                  {a, b}   <= idx_inc;
                  wait_cnt <= '0;
                  state    <= WAIT;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : comp_checker
